prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
Writer-side companion to the basic computer's program memory. It accepts a framed byte stream over a valid/ready handshake and writes it into a 16x8 program SRAM. It checks an XOR checksum, then releases the CPU to run. The CPU fetch path reads the same SRAM through an asynchronous read port, and cpu_run gates the CPU clock enable (ON_OFF).

Parameters:
ADDR_W, 4, program memory address width
DATA_W, 8, instruction/data word width
DEPTH, 16, number of memory words (2**ADDR_W)

Ports:
clk_master  in  1  single system clock, rising edge
reset_n  in  1  reset, asynchronous, active-low
load_start  in  1  one-cycle pulse; begins a new frame, aborting any load in progress
in_valid  in  1  byte on in_data is valid
in_data  in  DATA_W  frame byte
in_ready  out  1  loader accepts a byte this cycle
cpu_addr  in  ADDR_W  CPU fetch/operand address
cpu_data  out  DATA_W  combinational read: mem[cpu_addr]
cpu_run  out  1  high only in DONE; drives CPU ON_OFF
load_done  out  1  high in DONE
load_err  out  1  high in ERR
words_loaded  out  ADDR_W+1  count of data bytes written in current frame

Behaviour:
- Transfer: a byte is accepted on a rising edge only when in_valid & in_ready.
- in_valid may drop at any time; there is no data loss and no timeout.
- Frame format: LEN byte L (1..DEPTH), then L data bytes, then CHK byte.
- CHK must equal the XOR of the L data bytes.
- Reset (reset_n low, async):
  - state=IDLE, in_ready=0, cpu_run=0, load_done=0, load_err=0.
  - words_loaded=0; internal addr/len/xor registers = 0.
  - Memory contents are not reset.
- States and transitions:
  - IDLE: in_ready=0. load_start -> LEN.
  - LEN: in_ready=1. On accept:
    - L==0 or L>DEPTH -> ERR.
    - Otherwise latch L, clear addr, words_loaded and xor, then -> DATA.
  - DATA: in_ready=1. On accept:
    - mem[addr] <= in_data; xor ^= in_data; addr++; words_loaded++.
    - When words_loaded reaches L -> CHK.
  - CHK: in_ready=1. On accept:
    - in_data==xor -> DONE; otherwise -> ERR.
  - DONE: in_ready=0, cpu_run=1, load_done=1. load_start -> LEN.
  - ERR: in_ready=0, load_err=1, cpu_run=0. load_start -> LEN.
- Status timing: load_done/load_err assert the cycle after the CHK (or bad LEN) accept. They are registered state decodes.
- load_start in any state other than IDLE:
  - Forces LEN on the next edge and drops cpu_run and status the same edge.
  - Takes priority over a simultaneous byte accept, which is ignored and does not write memory.
- Memory after a load:
  - Words already written during an aborted or failed frame stay written.
  - Words at addresses >= L keep their prior contents.
- Write address: a write at address 15 ends DATA because L<=16; addr never wraps within a frame.
- cpu_data is combinational from cpu_addr at all times. It is guaranteed meaningful only while cpu_run=1.
- If the CPU address equals the write address in the same cycle, cpu_data shows the old word; the new word is visible after the edge.
- Async reset mid-frame: immediate return to IDLE with cpu_run=0. Bytes already written stay in memory.

Test Plan:
- Reset, load_start, stream 03,E0,29,8A,43 with in_valid held high:
  - load_done=1 one cycle after the 43 accept; cpu_run=1; words_loaded=3.
  - cpu_addr=1 -> cpu_data=29.
- Same frame with CHK=44:
  - load_err=1, cpu_run=0.
  - mem[0..2] still read E0,29,8A.
- LEN=00, then a separate frame with LEN=11 (hex):
  - Each -> ERR right after the LEN accept; in_ready=0 afterwards.
  - No memory write; words_loaded=0.
- Backpressure: frame 02,0C,05,09 with in_valid toggling 1,0,0,1,0,1,1:
  - Exactly 4 accepts; mem[0]=0C, mem[1]=05; DONE reached.
- load_start asserted in DATA after 1 of 4 bytes, in the same cycle as a valid byte:
  - Byte ignored; state LEN; words_loaded cleared by the new LEN.
  - The new frame 01,FF,FF -> DONE with mem[0]=FF.
- reset_n pulsed low asynchronously mid-DATA:
  - in_ready, cpu_run, load_done and load_err drop immediately; state IDLE.
  - Earlier written bytes remain readable.

Source files
------------

// File: rtl/prog_loader.sv
// Program-memory loader: receives a LEN/data/CHK framed byte stream, writes a
// 16x8 program SRAM, verifies an XOR checksum and then enables the CPU.
module prog_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk_master,
  input  logic              reset_n,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_data,
  output logic              cpu_run,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q,   len_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] xor_q,   xor_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              accept;
  logic              mem_we;

  logic [DATA_W-1:0] mem_q [DEPTH];

  assign accept = in_valid & in_ready;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    addr_d   = addr_q;
    xor_d    = xor_q;
    words_d  = words_q;
    mem_we   = 1'b0;
    in_ready = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);

    // load_start wins over a same-cycle accept; that byte is dropped unwritten
    if (load_start) begin
      state_d = S_LEN;
    end else if (accept) begin
      unique case (state_q)
        S_LEN: begin
          addr_d  = '0;
          words_d = '0;
          xor_d   = '0;
          if ((in_data == '0) || (in_data > DATA_W'(DEPTH))) begin
            state_d = S_ERR;
          end else begin
            len_d   = in_data[ADDR_W:0];
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          mem_we  = 1'b1;
          xor_d   = xor_q ^ in_data;
          addr_d  = addr_q + ADDR_W'(1);
          words_d = words_q + (ADDR_W+1)'(1);
          if (words_d == len_q) state_d = S_CHK;
        end
        S_CHK: begin
          state_d = (in_data == xor_q) ? S_DONE : S_ERR;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_master or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      addr_q  <= '0;
      xor_q   <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      xor_q   <= xor_d;
      words_q <= words_d;
    end
  end

  // Storage is deliberately not reset so a program survives reset pulses.
  always_ff @(posedge clk_master) begin
    if (mem_we) mem_q[addr_q] <= in_data;
  end

  assign cpu_data     = mem_q[cpu_addr];
  assign cpu_run      = (state_q == S_DONE);
  assign load_done    = (state_q == S_DONE);
  assign load_err     = (state_q == S_ERR);
  assign words_loaded = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: framing, checksum, LEN bounds,
// backpressure, abort by load_start and asynchronous reset.
module tb_prog_loader;

  logic       clk_master = 1'b0;
  logic       reset_n;
  logic       load_start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_data;
  logic       cpu_run;
  logic       load_done;
  logic       load_err;
  logic [4:0] words_loaded;

  int n_cmp = 0;
  int n_err = 0;

  prog_loader #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) dut (
    .clk_master   (clk_master),
    .reset_n      (reset_n),
    .load_start   (load_start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .cpu_addr     (cpu_addr),
    .cpu_data     (cpu_data),
    .cpu_run      (cpu_run),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk_master = ~clk_master;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk_master);
    #1;
  endtask

  task automatic pulse_start();
    sync();
    load_start = 1'b1;
    sync();
    load_start = 1'b0;
  endtask

  // One byte per cycle; in_valid stays high across back-to-back calls.
  task automatic send(input logic [7:0] b, input string tag);
    in_valid = 1'b1;
    in_data  = b;
    check({tag, " ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk_master);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic peek(input logic [3:0] a, input logic [7:0] exp, input string tag);
    cpu_addr = a;
    #1;
    check(tag, {24'd0, cpu_data}, {24'd0, exp});
  endtask

  task automatic status(input string tag, input logic rdy, input logic run,
                        input logic done, input logic err);
    check({tag, " in_ready"},  {31'd0, in_ready},  {31'd0, rdy});
    check({tag, " cpu_run"},   {31'd0, cpu_run},   {31'd0, run});
    check({tag, " load_done"}, {31'd0, load_done}, {31'd0, done});
    check({tag, " load_err"},  {31'd0, load_err},  {31'd0, err});
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    load_start = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    #3;
    status("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst words", {27'd0, words_loaded}, 32'd0);
    sync();
    reset_n = 1'b1;
    sync();
    check("idle ready", {31'd0, in_ready}, 32'd0);
  endtask

  logic [7:0] bp_frame [4];
  logic       bp_valid [7];

  initial begin
    cpu_addr = 4'd0;
    #2;
    do_reset();

    // Good 3-word frame
    pulse_start();
    check("len ready", {31'd0, in_ready}, 32'd1);
    send(8'h03, "g len");
    send(8'hE0, "g d0");
    send(8'h29, "g d1");
    send(8'h8A, "g d2");
    check("g pre-chk done", {31'd0, load_done}, 32'd0);
    send(8'h43, "g chk");
    status("g done", 1'b0, 1'b1, 1'b1, 1'b0);
    check("g words", {27'd0, words_loaded}, 32'd3);
    peek(4'd1, 8'h29, "g mem1");

    // Restart drops run/status on the same edge; bad checksum
    pulse_start();
    check("restart run", {31'd0, cpu_run}, 32'd0);
    check("restart done", {31'd0, load_done}, 32'd0);
    send(8'h03, "b len");
    send(8'hE0, "b d0");
    send(8'h29, "b d1");
    send(8'h8A, "b d2");
    send(8'h44, "b chk");
    status("b err", 1'b0, 1'b0, 1'b0, 1'b1);
    peek(4'd0, 8'hE0, "b mem0");
    peek(4'd1, 8'h29, "b mem1");
    peek(4'd2, 8'h8A, "b mem2");

    // LEN = 0 and LEN = 0x11 (low bits alone would look like 1)
    do_reset();
    pulse_start();
    send(8'h00, "l0 len");
    status("l0", 1'b0, 1'b0, 1'b0, 1'b1);
    check("l0 words", {27'd0, words_loaded}, 32'd0);
    pulse_start();
    send(8'h11, "l11 len");
    status("l11", 1'b0, 1'b0, 1'b0, 1'b1);
    check("l11 words", {27'd0, words_loaded}, 32'd0);
    peek(4'd0, 8'hE0, "l11 mem0");

    // Full-depth frame: data 0x10..0x1F, XOR = 0x00
    pulse_start();
    send(8'h10, "f len");
    for (int i = 0; i < 16; i++) send(8'h10 + 8'(i), "f data");
    check("f pre-chk words", {27'd0, words_loaded}, 32'd16);
    send(8'h00, "f chk");
    status("f done", 1'b0, 1'b1, 1'b1, 1'b0);
    peek(4'd0,  8'h10, "f mem0");
    peek(4'd15, 8'h1F, "f mem15");

    // Backpressure: frame 02,0C,05,09 under in_valid 1,0,0,1,0,1,1
    bp_frame = '{8'h02, 8'h0C, 8'h05, 8'h09};
    bp_valid = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    pulse_start();
    begin
      int idx;
      int acc;
      idx = 0;
      acc = 0;
      for (int c = 0; c < 7; c++) begin
        in_valid = bp_valid[c];
        in_data  = bp_frame[idx < 4 ? idx : 3];
        if (in_valid && in_ready) begin
          idx++;
          acc++;
        end
        @(posedge clk_master);
        #1;
      end
      in_valid = 1'b0;
      check("bp accepts", acc, 32'd4);
    end
    check("bp done", {31'd0, load_done}, 32'd1);
    peek(4'd0, 8'h0C, "bp mem0");
    peek(4'd1, 8'h05, "bp mem1");
    peek(4'd2, 8'h12, "bp mem2 kept");

    // Abort in DATA with a simultaneous valid byte
    pulse_start();
    send(8'h04, "a len");
    send(8'hAA, "a d0");
    in_valid   = 1'b1;
    in_data    = 8'hBB;
    load_start = 1'b1;
    sync();
    load_start = 1'b0;
    in_valid   = 1'b0;
    check("a in LEN ready", {31'd0, in_ready}, 32'd1);
    peek(4'd1, 8'h05, "a byte dropped");
    send(8'h01, "a2 len");
    check("a2 words cleared", {27'd0, words_loaded}, 32'd0);
    send(8'hFF, "a2 d0");
    send(8'hFF, "a2 chk");
    status("a2 done", 1'b0, 1'b1, 1'b1, 1'b0);
    check("a2 words", {27'd0, words_loaded}, 32'd1);
    peek(4'd0, 8'hFF, "a2 mem0");

    // Async reset mid-DATA, with read-during-write on address 0
    pulse_start();
    send(8'h03, "r len");
    in_valid = 1'b1;
    in_data  = 8'h5A;
    cpu_addr = 4'd0;
    #1;
    check("r old word", {24'd0, cpu_data}, 32'hFF);
    @(posedge clk_master);
    #1;
    in_valid = 1'b0;
    check("r new word", {24'd0, cpu_data}, 32'h5A);
    check("r in DATA", {31'd0, in_ready}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    status("r async", 1'b0, 1'b0, 1'b0, 1'b0);
    sync();
    reset_n = 1'b1;
    sync();
    status("r idle", 1'b0, 1'b0, 1'b0, 1'b0);
    peek(4'd0, 8'h5A, "r mem0");
    peek(4'd1, 8'h05, "r mem1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
